// File: rtl/cluster_unpacker.sv
// Expands an 8-cluster-per-bx frame into a 1536-pad S-bit image, one cluster per clock4x cycle.
// Optional build macro CLUSTER_UNPACKER_SKIP_EN: stop the frame at the first invalid cluster.

module cluster_unpacker_row #(
    parameter int MXKEYS = 192
) (
    input  logic              clock4x,
    input  logic              global_reset,
    input  logic              clr,
    input  logic              hit,
    input  logic [MXKEYS-1:0] mask,
    output logic [MXKEYS-1:0] acc
);
    always_ff @(posedge clock4x) begin
        if (global_reset || clr) acc <= '0;
        else if (hit)            acc <= acc | mask;
    end
endmodule

module cluster_unpacker #(
    parameter int MXSBITS    = 64,
    parameter int MXKEYS     = 3*MXSBITS,
    parameter int MXROWS     = 8,
    parameter int MXPADS     = MXROWS*MXKEYS,
    parameter int MXADRBITS  = 11,
    parameter int MXCNTBITS  = 3,
    parameter int MXCLSTBITS = 14,
    parameter int MXCLUSTERS = 8
) (
    input  logic                  clock4x,
    input  logic                  global_reset,
    input  logic                  clusters_valid,
    input  logic [MXCLSTBITS-1:0] cluster0,
    input  logic [MXCLSTBITS-1:0] cluster1,
    input  logic [MXCLSTBITS-1:0] cluster2,
    input  logic [MXCLSTBITS-1:0] cluster3,
    input  logic [MXCLSTBITS-1:0] cluster4,
    input  logic [MXCLSTBITS-1:0] cluster5,
    input  logic [MXCLSTBITS-1:0] cluster6,
    input  logic [MXCLSTBITS-1:0] cluster7,
    output logic                  ready,
    output logic                  sbits_valid,
    output logic [MXSBITS-1:0]    vfat0,
    output logic [MXSBITS-1:0]    vfat1,
    output logic [MXSBITS-1:0]    vfat2,
    output logic [MXSBITS-1:0]    vfat3,
    output logic [MXSBITS-1:0]    vfat4,
    output logic [MXSBITS-1:0]    vfat5,
    output logic [MXSBITS-1:0]    vfat6,
    output logic [MXSBITS-1:0]    vfat7,
    output logic [MXSBITS-1:0]    vfat8,
    output logic [MXSBITS-1:0]    vfat9,
    output logic [MXSBITS-1:0]    vfat10,
    output logic [MXSBITS-1:0]    vfat11,
    output logic [MXSBITS-1:0]    vfat12,
    output logic [MXSBITS-1:0]    vfat13,
    output logic [MXSBITS-1:0]    vfat14,
    output logic [MXSBITS-1:0]    vfat15,
    output logic [MXSBITS-1:0]    vfat16,
    output logic [MXSBITS-1:0]    vfat17,
    output logic [MXSBITS-1:0]    vfat18,
    output logic [MXSBITS-1:0]    vfat19,
    output logic [MXSBITS-1:0]    vfat20,
    output logic [MXSBITS-1:0]    vfat21,
    output logic [MXSBITS-1:0]    vfat22,
    output logic [MXSBITS-1:0]    vfat23,
    output logic [3:0]            n_clusters,
    output logic [7:0]            overflow_cnt
);
    localparam int NVFAT = MXPADS / MXSBITS;
    localparam int ROWW  = $clog2(MXROWS);
    localparam int KEYW  = $clog2(MXKEYS);
    localparam int IDXW  = $clog2(MXCLUSTERS);
    localparam int SPANW = 2**MXCNTBITS;

    typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;
    state_t state, state_nxt;

    logic [MXCLUSTERS-1:0][MXCLSTBITS-1:0] clst_q;
    logic [IDXW-1:0]                       idx;
    logic [3:0]                            vcnt;
    logic [MXROWS-1:0][MXKEYS-1:0]         acc;
    logic [NVFAT-1:0][MXSBITS-1:0]         vfat_q;

    logic [MXCLSTBITS-1:0] cur;
    logic [MXADRBITS-1:0]  cur_adr, base;
    logic [MXCNTBITS-1:0]  cur_cnt;
    logic                  cur_valid, accept;
    logic [ROWW-1:0]       row;
    logic [KEYW-1:0]       key;
    logic [SPANW-1:0]      span;
    logic [MXKEYS-1:0]     mask;

    assign cur       = clst_q[idx];
    assign cur_adr   = cur[MXADRBITS-1:0];
    assign cur_cnt   = cur[MXCLSTBITS-1:MXADRBITS];
    assign cur_valid = cur_adr < MXADRBITS'(MXPADS);
    assign accept    = (state == IDLE) && clusters_valid;

    // row/key by comparison against row bases; mask saturates at the row end by width
    always_comb begin
        row  = '0;
        base = '0;
        for (int k = 1; k < MXROWS; k++) begin
            if (cur_adr >= MXADRBITS'(k*MXKEYS)) begin
                row  = ROWW'(k);
                base = MXADRBITS'(k*MXKEYS);
            end
        end
        key  = KEYW'(cur_adr - base);
        span = SPANW'(((SPANW+1)'(2) << cur_cnt) - (SPANW+1)'(1));
        mask = {{(MXKEYS-SPANW){1'b0}}, span} << key;
    end

    for (genvar r = 0; r < MXROWS; r++) begin : g_row
        cluster_unpacker_row #(.MXKEYS(MXKEYS)) u_row (
            .clock4x      (clock4x),
            .global_reset (global_reset),
            .clr          (accept),
            .hit          ((state == PROC) && cur_valid && (row == ROWW'(r))),
            .mask         (mask),
            .acc          (acc[r])
        );
    end

    always_ff @(posedge clock4x) begin
        if (global_reset) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (clusters_valid) state_nxt = PROC;
            end
`ifdef CLUSTER_UNPACKER_SKIP_EN
            PROC: if (!cur_valid || idx == IDXW'(MXCLUSTERS-1)) state_nxt = DONE;
`else
            PROC: if (idx == IDXW'(MXCLUSTERS-1)) state_nxt = DONE;
`endif
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock4x) begin
        if (global_reset) begin
            clst_q       <= '0;
            idx          <= '0;
            vcnt         <= '0;
            sbits_valid  <= 1'b0;
            n_clusters   <= '0;
            overflow_cnt <= '0;
            vfat_q       <= '0;
        end else begin
            sbits_valid <= 1'b0;
            if (accept) begin
                clst_q <= {cluster7, cluster6, cluster5, cluster4,
                           cluster3, cluster2, cluster1, cluster0};
                idx    <= '0;
                vcnt   <= '0;
            end
            if (state == PROC) begin
                idx <= idx + 1'b1;
                if (cur_valid) vcnt <= vcnt + 4'd1;
            end
            if (state == DONE) begin
                sbits_valid <= 1'b1;
                n_clusters  <= vcnt;
                for (int n = 0; n < NVFAT; n++)
                    vfat_q[n] <= acc[n % MXROWS][MXSBITS*(n / MXROWS) +: MXSBITS];
            end
            // any strobe outside IDLE (including the DONE edge) is a dropped frame
            if (clusters_valid && state != IDLE && overflow_cnt != 8'hFF)
                overflow_cnt <= overflow_cnt + 8'd1;
        end
    end

    assign vfat0  = vfat_q[0];
    assign vfat1  = vfat_q[1];
    assign vfat2  = vfat_q[2];
    assign vfat3  = vfat_q[3];
    assign vfat4  = vfat_q[4];
    assign vfat5  = vfat_q[5];
    assign vfat6  = vfat_q[6];
    assign vfat7  = vfat_q[7];
    assign vfat8  = vfat_q[8];
    assign vfat9  = vfat_q[9];
    assign vfat10 = vfat_q[10];
    assign vfat11 = vfat_q[11];
    assign vfat12 = vfat_q[12];
    assign vfat13 = vfat_q[13];
    assign vfat14 = vfat_q[14];
    assign vfat15 = vfat_q[15];
    assign vfat16 = vfat_q[16];
    assign vfat17 = vfat_q[17];
    assign vfat18 = vfat_q[18];
    assign vfat19 = vfat_q[19];
    assign vfat20 = vfat_q[20];
    assign vfat21 = vfat_q[21];
    assign vfat22 = vfat_q[22];
    assign vfat23 = vfat_q[23];
endmodule

// File: doc/cluster_unpacker.md
Name: cluster_unpacker

Overview:
Decoder for the 8-cluster-per-bx stream that the cluster packer produces. It captures one frame of eight 14-bit clusters ({cnt[2:0], adr[10:0]}) and expands them into a 1536-pad S-bit image, one cluster per clock4x cycle. It presents the image as 24 VFAT-ordered 64-bit words with a one-cycle valid strobe. It serves as the golden-model / loopback checker for the packer and as the trigger-side S-bit reconstructor.

Parameters:
MXSBITS, 64, S-bits per VFAT
MXKEYS, 192, pads per eta partition (3*MXSBITS)
MXROWS, 8, eta partitions
MXPADS, 1536, pads per chamber (24*MXSBITS)
MXADRBITS, 11, address bits per cluster
MXCNTBITS, 3, count bits per cluster
MXCLSTBITS, 14, bits per cluster
MXCLUSTERS, 8, clusters per frame

Ports:
clock4x  input  1  single clock for all logic
global_reset  input  1  synchronous, active-high reset
clusters_valid  input  1  frame strobe; cluster0..7 sampled when high and ready=1
cluster0 .. cluster7  input  14 each  {cnt[13:11], adr[10:0]}
ready  output  1  high when idle and able to accept a frame
sbits_valid  output  1  one-cycle pulse; image outputs updated this cycle
vfat0 .. vfat23  output  64 each  reconstructed S-bits
n_clusters  output  4  number of valid clusters decoded in the presented frame (0..8)
overflow_cnt  output  8  saturating count of frames dropped while busy

Behaviour:
- Reset is synchronous and active-high: global_reset is sampled on the clock4x edge. When asserted, the state goes to IDLE, the accumulator and all vfat outputs become 0, and sbits_valid=0, n_clusters=0, overflow_cnt=0, ready=1 from the next cycle.
- A reset asserted in the middle of a frame aborts the frame. No sbits_valid is produced for it.
- Address map: adr = row*192 + key, with row 0..7 and key 0..191. A value adr >= 1536 (e.g. 0x7FF) is an invalid/empty cluster and is ignored.
- A cluster sets pads key..key+cnt (size cnt+1, 1..8) within its row.
  - Bits beyond key 191 are truncated; they never spill into the next row.
  - Overlapping clusters OR together.
- Row-to-VFAT map: vfat n takes row n%8, keys 64*(n/8) .. 64*(n/8)+63, LSB = lowest key. Example: vfat16 = row 0, keys 128..191.
- State machine: IDLE -> CAPTURE/PROC -> DONE -> IDLE.
  - IDLE: ready=1. On clusters_valid at edge T:
    - latch all eight clusters;
    - clear the accumulator and the valid-count;
    - ready=0;
    - index i=0.
  - PROC, edges T+1..T+8: decode cluster i, OR it into the accumulator, increment the valid-count if the cluster is valid, then i++. After i=7, go to DONE.
  - DONE, edge T+9:
    - copy the accumulator to vfat0..23;
    - n_clusters = valid-count;
    - sbits_valid=1 for exactly one cycle;
    - return to IDLE (ready=1 after edge T+9).
- Latency: clusters_valid at edge T gives sbits_valid high in the cycle following edge T+9 (9 clocks). Throughput is one frame per 10 clocks.
- vfat outputs and n_clusters hold their values between frames.
- clusters_valid while ready=0: the frame is dropped and overflow_cnt increments, saturating at 255. A dropped frame does not disturb the frame in flight.
- clusters_valid in the same cycle as the DONE edge is treated as busy and dropped. The next acceptance is possible one cycle later.
- Decoder arithmetic: row = adr/192 and key = adr%192. These are computed by comparison against the constants 192*k, with no divider. The span mask is ((2^(cnt+1))-1) << key, masked to 192 bits.

Optional Feature:
CLUSTER_UNPACKER_SKIP_EN
- Defined: the packer emits valid clusters first, so the first invalid cluster encountered in PROC ends the frame. The next edge is DONE.
  - Latency = 2 + number of leading valid clusters, capped at 9.
  - An all-invalid frame gives sbits_valid 2 clocks after capture, with n_clusters=0 and an all-zero image.
  - Valid clusters after the first invalid one are ignored.
- Undefined: all eight clusters are always processed. Fixed 9-clock latency.

Test Plan:
- Reset, then cluster0 = {3'd2, 11'd5}, others 0x7FF, strobe -> 9 clocks later sbits_valid=1, vfat0 = 0x00000000000000E0, all other vfats 0, n_clusters=1.
- cluster0 = {3'd7, 11'd188} (row0 key188), cluster1 = {3'd0, 11'd192} -> vfat16 bits 60..63 set (row-end truncation, nothing in row1 key0 from cluster0); vfat1 bit0 set from cluster1; n_clusters=2.
- Eight overlapping clusters: adr 1535 cnt0 plus adr 100 cnt3 and adr 102 cnt3 -> vfat23 bit63 set; vfat8 bits 36..41 set (OR of overlap); invalid clusters ignored.
- Second strobe 3 clocks after the first -> overflow_cnt=1 and the first frame's output is unchanged. 300 dropped frames -> overflow_cnt=255.
- global_reset at edge T+4 of a frame -> no sbits_valid, all vfats 0, ready=1 next cycle. A new frame afterwards decodes correctly.
- With CLUSTER_UNPACKER_SKIP_EN: two valid clusters then 0x7FF -> sbits_valid 4 clocks after capture; all-invalid frame -> 2 clocks. Without the macro: 9 clocks in both cases.
